// File: rtl/serial_bit_source_pkg.sv
// ---------------------------------------------------------------------------
// serial_bit_source_pkg
//   Shared definitions for the serial bit source and the Moore sequence
//   detector it feeds. Both blocks use the same 2-bit state width, so the
//   constants live here rather than in either module.
//
//   Contents:
//     DEFAULT_WIDTH  default word width for the serialiser
//     state_t        2-bit state encoding (IDLE / SHIFT / DONE)
// ---------------------------------------------------------------------------
package serial_bit_source_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'b11 is deliberately left unused; the serialiser treats it as
    // illegal and returns to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_bit_source.sv
// ---------------------------------------------------------------------------
// serial_bit_source
//   Parallel-to-serial stage that drives the single-bit input w of the Moore
//   sequence detector. A WIDTH-bit word is captured on a load strobe and
//   shifted out MSB first, one bit per clock. Outputs depend only on the
//   registered state, so w is glitch-free and never follows the inputs
//   combinationally.
//
//   Parameters:
//     WIDTH       bits per word (2..32)
//     IDLE_LEVEL  value held on w while not shifting
//
//   Ports:
//     Clock    in   rising-edge clock
//     Resetn   in   asynchronous active-low reset
//     load     in   capture request, honoured only while ready=1
//     data_in  in   word to serialise, sampled only on the accepting edge
//     w        out  serial bit stream (registered)
//     busy     out  high while shifting
//     ready    out  high in IDLE or DONE (always ~busy)
//     done     out  one-cycle pulse after the last bit of a word
// ---------------------------------------------------------------------------
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             w,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             w_reg;
    logic             w_next;

    // Next-state logic. The bit placed on w is computed one edge ahead so
    // that w itself can be a plain register. data_in is only looked at on an
    // accepting edge, so an unknown word outside that edge never reaches
    // the shift register.
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        w_next     = IDLE_LEVEL;

        case (state)
            IDLE, DONE: begin
                if (load) begin
                    state_next = SHIFT;
                    sreg_next  = data_in;
                    cnt_next   = '0;
                    w_next     = data_in[WIDTH-1];
                end else begin
                    state_next = IDLE;
                end
            end

            SHIFT: begin
                sreg_next = sreg << 1;
                // The counter stops at the last bit instead of wrapping.
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                    w_next     = IDLE_LEVEL;
                end else begin
                    cnt_next = cnt + 1'b1;
                    w_next   = sreg[WIDTH-2];
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, shift register, bit counter and serial output register.
    // Reset aborts any word in flight without producing a done pulse.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            w_reg <= IDLE_LEVEL;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
            w_reg <= w_next;
        end
    end

    assign w     = w_reg;
    assign busy  = (state == SHIFT);
    assign ready = ~busy;
    assign done  = (state == DONE);

endmodule
